reset_seq_watchdog: RTL and testbench
=====================================

Name: reset_seq_watchdog

Overview:
- Synthesisable, parametrised successor to the bench-level clock/reset/timeout logic.
- Generates NUM_RST staggered active-low reset releases from one active-high synchronous reset.
- Counts run cycles, flags a global timeout, and detects a stall when no heartbeat arrives within a window.
- Used in the top-level bench and on FPGA bring-up builds to sequence subsystem resets and end runaway runs.

Parameters:
- NUM_RST, 3: number of reset output channels (>=1).
- RST_HOLD, 10: edges after rst deassertion before channel 0 is released (>=1).
- RST_STAGGER, 2: extra edges between consecutive channel releases (>=0).
- TIMEOUT_CYCLES, 20: RUN cycles before timeout (>=1, must fit CNT_W).
- IDLE_LIMIT, 8: edges without heartbeat before stall; 0 disables stall detection.
- CNT_W, 32: width of cycle_o and the idle counter.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- heartbeat_i  in  1  progress pulse from the DUT; clears the idle counter.
- done_i  in  1  DUT completion; honoured only in RUN.
- rst_n_o  out  NUM_RST  per-channel active-low reset, registered.
- run_o  out  1  high while in RUN.
- cycle_o  out  CNT_W  RUN cycle count.
- done_o  out  1  sticky, terminal DONE.
- timeout_o  out  1  sticky, terminal TIMEOUT.
- stall_o  out  1  sticky, terminal STALL.
- state_o  out  3  HOLD=0, RUN=1, DONE=2, TIMEOUT=3, STALL=4.

Behaviour:
- All outputs are registered.
- rst sampled high forces, at that edge: rst_n_o=0, run_o=0, cycle_o=0, done_o/timeout_o/stall_o=0, state=HOLD, seq and idle counters=0.
- Applies from any state, including mid-RUN and terminal states. A full re-sequence follows.
- HOLD:
  - seq counter increments each edge with rst low; first such edge gives seq=1.
  - rst_n_o[i] sets at the edge where seq reaches RST_HOLD + i*RST_STAGGER and stays 1 until rst.
  - With RST_STAGGER=0, all channels release on the same edge.
- HOLD->RUN on the same edge as the last channel release: run_o=1, cycle_o=0, idle=0.
- RUN:
  - cycle_o increments by 1 each edge.
  - idle counter: cleared to 0 when heartbeat_i is sampled high, otherwise increments.
- Exits from RUN, evaluated on the same edge, priority DONE > TIMEOUT > STALL:
  - done_i high -> DONE.
  - Next cycle_o == TIMEOUT_CYCLES -> TIMEOUT.
  - IDLE_LIMIT != 0 and next idle == IDLE_LIMIT -> STALL.
- On any exit:
  - run_o=0 and the matching sticky flag is set.
  - cycle_o freezes, with the increment of the exit edge included.
  - rst_n_o stays high.
  - Terminal states persist until rst.
- done_i and heartbeat_i are ignored in HOLD and in terminal states.
- Counters never wrap: RUN always ends no later than TIMEOUT_CYCLES.
- Invalid parameters (NUM_RST=0, RST_HOLD=0, TIMEOUT_CYCLES >= 2**CNT_W) raise an elaboration-time $error.

Test Plan:
- Defaults; rst high for 3 edges, then low; heartbeat every 4 cycles -> rst_n_o[0] rises at edge 10, [1] at 12, [2] at 14, run_o=1 from edge 14; timeout_o=1, state_o=3, cycle_o=20 at edge 34; all other flags stay 0.
- Defaults; done_i high at edge 20 -> done_o=1, state_o=2, cycle_o=6, run_o=0; later done_i or heartbeat pulses change nothing.
- Defaults; no heartbeat after RUN entry -> stall_o=1, state_o=4 at edge 22, cycle_o=8.
- Defaults; done_i high on the edge where cycle_o would reach 20 -> done_o=1, timeout_o=0.
- Defaults; rst reasserted at edge 25 in RUN -> rst_n_o=0, cycle_o=0, flags cleared; the release sequence repeats at +10/+12/+14 edges.
- NUM_RST=4, RST_STAGGER=0, IDLE_LIMIT=0, no heartbeat -> all four channels rise at edge 10; no stall; timeout at edge 30.

Source files
------------

// File: rtl/reset_seq_watchdog.sv
// -----------------------------------------------------------------------------
// reset_seq_watchdog
//
// Sequences NUM_RST staggered active-low reset releases from one active-high
// synchronous reset, then supervises the run: counts RUN cycles, ends the run
// on completion, on a global cycle timeout, or on a heartbeat stall. Terminal
// states are sticky until rst.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst          synchronous reset, active-high
//   heartbeat_i  progress pulse, clears the idle counter while running
//   done_i       completion request, honoured only while running
//   rst_n_o      per-channel active-low reset, registered
//   run_o        high while running
//   cycle_o      RUN cycle count, frozen on exit (exit edge included)
//   done_o       sticky completion flag
//   timeout_o    sticky timeout flag
//   stall_o      sticky stall flag
//   state_o      HOLD=0, RUN=1, DONE=2, TIMEOUT=3, STALL=4
// -----------------------------------------------------------------------------
module reset_seq_watchdog #(
   parameter int NUM_RST        = 3,
   parameter int RST_HOLD       = 10,
   parameter int RST_STAGGER    = 2,
   parameter int TIMEOUT_CYCLES = 20,
   parameter int IDLE_LIMIT     = 8,
   parameter int CNT_W          = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               heartbeat_i,
   input  logic               done_i,
   output logic [NUM_RST-1:0] rst_n_o,
   output logic               run_o,
   output logic [CNT_W-1:0]   cycle_o,
   output logic               done_o,
   output logic               timeout_o,
   output logic               stall_o,
   output logic [2:0]         state_o
);

   localparam logic [2:0] S_HOLD    = 3'd0;
   localparam logic [2:0] S_RUN     = 3'd1;
   localparam logic [2:0] S_DONE    = 3'd2;
   localparam logic [2:0] S_TIMEOUT = 3'd3;
   localparam logic [2:0] S_STALL   = 3'd4;

   // Sequence counter only has to reach the last channel's release point.
   localparam int SEQ_MAX = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
   localparam int SEQ_W   = (SEQ_MAX < 1) ? 1 : $clog2(SEQ_MAX + 1);

   if (NUM_RST < 1) begin : g_bad_num_rst
      $error("reset_seq_watchdog: NUM_RST must be >= 1");
   end
   if (RST_HOLD < 1) begin : g_bad_rst_hold
      $error("reset_seq_watchdog: RST_HOLD must be >= 1");
   end
   if (RST_STAGGER < 0 || IDLE_LIMIT < 0) begin : g_bad_negative
      $error("reset_seq_watchdog: RST_STAGGER and IDLE_LIMIT must be >= 0");
   end
   if (TIMEOUT_CYCLES < 1 ||
       (CNT_W < 63 && 64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_timeout
      $error("reset_seq_watchdog: TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
   end

   function automatic logic [SEQ_W-1:0] release_point(input int ch);
      return SEQ_W'(RST_HOLD + ch * RST_STAGGER);
   endfunction

   logic [NUM_RST-1:0] rst_n_q, rst_n_d;
   logic               run_q, run_d;
   logic [CNT_W-1:0]   cycle_q, cycle_d;
   logic [CNT_W-1:0]   idle_q, idle_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               stall_q, stall_d;
   logic [2:0]         state_q, state_d;

   always_comb begin
      rst_n_d   = rst_n_q;
      run_d     = run_q;
      cycle_d   = cycle_q;
      idle_d    = idle_q;
      seq_d     = seq_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      stall_d   = stall_q;
      state_d   = state_q;

      case (state_q)
         S_HOLD: begin
            seq_d = seq_q + 1'b1;
            for (int i = 0; i < NUM_RST; i++) begin
               if (seq_d == release_point(i)) rst_n_d[i] = 1'b1;
            end
            // RUN starts on the same edge as the last channel release.
            if (seq_d == SEQ_W'(SEQ_MAX)) begin
               state_d = S_RUN;
               run_d   = 1'b1;
               cycle_d = '0;
               idle_d  = '0;
            end
         end
         S_RUN: begin
            cycle_d = cycle_q + 1'b1;
            idle_d  = heartbeat_i ? '0 : idle_q + 1'b1;
            // Exit priority: DONE > TIMEOUT > STALL; cycle_d is kept so the
            // frozen count includes the exit edge.
            if (done_i) begin
               state_d = S_DONE;
               run_d   = 1'b0;
               done_d  = 1'b1;
            end else if (cycle_d == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d   = S_TIMEOUT;
               run_d     = 1'b0;
               timeout_d = 1'b1;
            end else if (IDLE_LIMIT != 0 && idle_d == CNT_W'(IDLE_LIMIT)) begin
               state_d = S_STALL;
               run_d   = 1'b0;
               stall_d = 1'b1;
            end
         end
         default: begin
            // Terminal states hold everything until rst.
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_n_q   <= '0;
         run_q     <= 1'b0;
         cycle_q   <= '0;
         idle_q    <= '0;
         seq_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         stall_q   <= 1'b0;
         state_q   <= S_HOLD;
      end else begin
         rst_n_q   <= rst_n_d;
         run_q     <= run_d;
         cycle_q   <= cycle_d;
         idle_q    <= idle_d;
         seq_q     <= seq_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         state_q   <= state_d;
      end
   end

   assign rst_n_o   = rst_n_q;
   assign run_o     = run_q;
   assign cycle_o   = cycle_q;
   assign done_o    = done_q;
   assign timeout_o = timeout_q;
   assign stall_o   = stall_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_reset_seq_watchdog.sv
// Bench for reset_seq_watchdog: a default instance and a NUM_RST=4,
// RST_STAGGER=0, IDLE_LIMIT=0 instance share the stimulus. Edge 0 is the last
// edge with rst high; edge n is the n-th edge after release.
module tb_reset_seq_watchdog;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hb  = 1'b0;
   logic        dn  = 1'b0;

   logic [2:0]  a_rst_n;
   logic        a_run, a_done, a_to, a_st;
   logic [31:0] a_cyc;
   logic [2:0]  a_state;

   logic [3:0]  b_rst_n;
   logic        b_run, b_done, b_to, b_st;
   logic [31:0] b_cyc;
   logic [2:0]  b_state;

   always #5 clk = ~clk;

   reset_seq_watchdog u_dut_a (
      .clk(clk), .rst(rst), .heartbeat_i(hb), .done_i(dn),
      .rst_n_o(a_rst_n), .run_o(a_run), .cycle_o(a_cyc), .done_o(a_done),
      .timeout_o(a_to), .stall_o(a_st), .state_o(a_state));

   reset_seq_watchdog #(.NUM_RST(4), .RST_STAGGER(0), .IDLE_LIMIT(0)) u_dut_b (
      .clk(clk), .rst(rst), .heartbeat_i(hb), .done_i(dn),
      .rst_n_o(b_rst_n), .run_o(b_run), .cycle_o(b_cyc), .done_o(b_done),
      .timeout_o(b_to), .stall_o(b_st), .state_o(b_state));

   typedef struct {
      int hb_per;   // heartbeat on edges that are multiples of this (0 = none)
      int hb_x;     // one extra heartbeat edge (-100 = none)
      int done_e;   // done_i edges (-100 = none)
      int done_e2;
      int rst_e;    // rst reassertion edge (-100 = none)
      int last_e;
   } scen_t;

   typedef struct {
      int          sc;
      int          dut;
      int          e;
      logic [3:0]  rst_n;
      logic        run;
      logic [31:0] cyc;
      logic        dn;
      logic        to;
      logic        st;
      logic [2:0]  state;
   } chk_t;

   scen_t scen[6];
   chk_t  tbl[$];
   chk_t  sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic add(input int sc, input int dut, input int e, input logic [3:0] rn,
                      input logic run, input int cyc, input logic d, input logic t,
                      input logic s, input logic [2:0] stt);
      chk_t c;
      c.sc = sc; c.dut = dut; c.e = e; c.rst_n = rn; c.run = run;
      c.cyc = 32'(cyc); c.dn = d; c.to = t; c.st = s; c.state = stt;
      tbl.push_back(c);
   endtask

   task automatic cmp(input string nm, input int sc, input int e,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL s%0d e%0d %s: got %0h expected %0h", sc, e, nm, act, exp);
      end
   endtask

   task automatic check(input chk_t c);
      if (c.dut == 0) begin
         cmp("rst_n", c.sc, c.e, {29'd0, a_rst_n}, {28'd0, c.rst_n});
         cmp("run",   c.sc, c.e, {31'd0, a_run},   {31'd0, c.run});
         cmp("cycle", c.sc, c.e, a_cyc,            c.cyc);
         cmp("done",  c.sc, c.e, {31'd0, a_done},  {31'd0, c.dn});
         cmp("tmo",   c.sc, c.e, {31'd0, a_to},    {31'd0, c.to});
         cmp("stall", c.sc, c.e, {31'd0, a_st},    {31'd0, c.st});
         cmp("state", c.sc, c.e, {29'd0, a_state}, {29'd0, c.state});
      end else begin
         cmp("b_rst_n", c.sc, c.e, {28'd0, b_rst_n}, {28'd0, c.rst_n});
         cmp("b_run",   c.sc, c.e, {31'd0, b_run},   {31'd0, c.run});
         cmp("b_cycle", c.sc, c.e, b_cyc,            c.cyc);
         cmp("b_done",  c.sc, c.e, {31'd0, b_done},  {31'd0, c.dn});
         cmp("b_tmo",   c.sc, c.e, {31'd0, b_to},    {31'd0, c.to});
         cmp("b_stall", c.sc, c.e, {31'd0, b_st},    {31'd0, c.st});
         cmp("b_state", c.sc, c.e, {29'd0, b_state}, {29'd0, c.state});
      end
   endtask

   initial begin
      // Scenarios: 0 timeout, 1 done + ignored pulses, 2 stall,
      // 3 done vs timeout on the same edge, 4 rst mid-RUN, 5 second instance.
      scen[0] = '{4,    -100, -100, -100, -100, 40};
      scen[1] = '{0,    26,   20,   25,   -100, 30};
      scen[2] = '{0,    -100, -100, -100, -100, 40};
      scen[3] = '{4,    -100, 34,   -100, -100, 36};
      scen[4] = '{4,    -100, -100, -100, 25,   40};
      scen[5] = '{0,    -100, -100, -100, -100, 32};

      //  sc dut  e   rst_n  run cyc dn to st state
      add(0, 0,  0, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0,  9, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0, 10, 4'b001, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0, 11, 4'b001, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0, 12, 4'b011, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0, 13, 4'b011, 0,  0, 0, 0, 0, 3'd0);
      add(0, 0, 14, 4'b111, 1,  0, 0, 0, 0, 3'd1);
      add(0, 0, 15, 4'b111, 1,  1, 0, 0, 0, 3'd1);
      add(0, 0, 33, 4'b111, 1, 19, 0, 0, 0, 3'd1);
      add(0, 0, 34, 4'b111, 0, 20, 0, 1, 0, 3'd3);
      add(0, 0, 40, 4'b111, 0, 20, 0, 1, 0, 3'd3);

      add(1, 0,  0, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(1, 0, 19, 4'b111, 1,  5, 0, 0, 0, 3'd1);
      add(1, 0, 20, 4'b111, 0,  6, 1, 0, 0, 3'd2);
      add(1, 0, 30, 4'b111, 0,  6, 1, 0, 0, 3'd2);

      add(2, 0,  0, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(2, 0, 21, 4'b111, 1,  7, 0, 0, 0, 3'd1);
      add(2, 0, 22, 4'b111, 0,  8, 0, 0, 1, 3'd4);
      add(2, 0, 40, 4'b111, 0,  8, 0, 0, 1, 3'd4);

      add(3, 0, 33, 4'b111, 1, 19, 0, 0, 0, 3'd1);
      add(3, 0, 34, 4'b111, 0, 20, 1, 0, 0, 3'd2);
      add(3, 0, 36, 4'b111, 0, 20, 1, 0, 0, 3'd2);

      add(4, 0, 24, 4'b111, 1, 10, 0, 0, 0, 3'd1);
      add(4, 0, 25, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(4, 0, 34, 4'b000, 0,  0, 0, 0, 0, 3'd0);
      add(4, 0, 35, 4'b001, 0,  0, 0, 0, 0, 3'd0);
      add(4, 0, 37, 4'b011, 0,  0, 0, 0, 0, 3'd0);
      add(4, 0, 39, 4'b111, 1,  0, 0, 0, 0, 3'd1);
      add(4, 0, 40, 4'b111, 1,  1, 0, 0, 0, 3'd1);

      add(5, 1,  0, 4'b0000, 0,  0, 0, 0, 0, 3'd0);
      add(5, 1,  9, 4'b0000, 0,  0, 0, 0, 0, 3'd0);
      add(5, 1, 10, 4'b1111, 1,  0, 0, 0, 0, 3'd1);
      add(5, 1, 29, 4'b1111, 1, 19, 0, 0, 0, 3'd1);
      add(5, 1, 30, 4'b1111, 0, 20, 0, 1, 0, 3'd3);
      add(5, 1, 32, 4'b1111, 0, 20, 0, 1, 0, 3'd3);

      for (int s = 0; s < 6; s++) begin
         // Expected results for this scenario go on the scoreboard up front
         // and are popped as the DUT reaches each edge.
         foreach (tbl[k]) if (tbl[k].sc == s) sb.push_back(tbl[k]);
         for (int e = -2; e <= scen[s].last_e; e++) begin
            rst = (e <= 0) || (e == scen[s].rst_e);
            hb  = ((scen[s].hb_per != 0) && (e % scen[s].hb_per == 0)) || (e == scen[s].hb_x);
            dn  = (e == scen[s].done_e) || (e == scen[s].done_e2);
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) check(sb.pop_front());
         end
         n_cmp++;
         if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL s%0d scoreboard: %0d checks left, expected 0", s, sb.size());
            sb.delete();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
